// File: rtl/trace_char_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : trace_char_arbiter
// Purpose  : Shares one character-stream trace checker between N_SRC trace
//            sources. The checker cannot stall, so each source's record
//            ('^' .. '#') is first captured whole into a line buffer. The
//            buffer is then replayed to the checker one char per cycle with no
//            gaps. After replay the checker result is sampled and reported,
//            tagged with the source id. Sources are served round-robin.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            src_valid/ready   - per-source char handshake
//            src_char          - per-source char, source i on [8i+7:8i]
//            chk_char          - registered char stream to the checker
//            chk_format_type   - checker result: [0] reg rec, [1] mem rec
//            chk_error_code    - checker error flags
//            res_valid         - one-cycle pulse, res_* valid
//            res_src/format/error - reported result
//            busy              - high whenever not IDLE
//            drop_cnt          - saturating count of discarded records
// Revision : 1.0 - initial release
// ============================================================================
module trace_char_arbiter #(
    parameter int         N_SRC     = 4,
    parameter int         SRC_W     = 2,
    parameter int         MAX_LEN   = 64,
    parameter int         LEN_W     = 7,
    parameter logic [7:0] IDLE_CHAR = 8'h00,
    parameter int         TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_SRC-1:0]     src_valid,
    input  logic [8*N_SRC-1:0]   src_char,
    output logic [N_SRC-1:0]     src_ready,
    output logic [7:0]           chk_char,
    input  logic [1:0]           chk_format_type,
    input  logic [3:0]           chk_error_code,
    output logic                 res_valid,
    output logic [SRC_W-1:0]     res_src,
    output logic [1:0]           res_format,
    output logic [3:0]           res_error,
    output logic                 busy,
    output logic [7:0]           drop_cnt
);

    localparam int             c_AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [2:0]     c_IDLE     = 3'd0;
    localparam logic [2:0]     c_CAPTURE  = 3'd1;
    localparam logic [2:0]     c_REPLAY   = 3'd2;
    localparam logic [2:0]     c_WAIT_RES = 3'd3;
    localparam logic [2:0]     c_REPORT   = 3'd4;
    localparam logic [7:0]     c_SOR      = 8'h5E;   // '^'
    localparam logic [7:0]     c_EOR      = 8'h23;   // '#'
    localparam logic [LEN_W-1:0] c_FULL   = LEN_W'(MAX_LEN);
    localparam logic [7:0]     c_TMO_LAST = 8'(TIMEOUT - 1);

    logic [2:0]       r_state;
    logic [SRC_W-1:0] r_last;
    logic [SRC_W-1:0] r_grant;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic [7:0]       r_tmo;
    logic [7:0]       r_chk_char;
    logic [SRC_W-1:0] r_res_src;
    logic [1:0]       r_res_format;
    logic [3:0]       r_res_error;
    logic [7:0]       r_drop_cnt;
    logic [7:0]       r_buf [MAX_LEN];

    logic             w_found;
    logic [SRC_W-1:0] w_pick;
    logic [N_SRC-1:0] w_ready;
    logic             w_xfer;
    logic [7:0]       w_char;
    logic             w_buf_we;
    logic [c_AW-1:0]  w_buf_waddr;

    // Round-robin scan starting at last+1. Iterating downwards lets the
    // closest candidate after r_last overwrite the farther ones.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = N_SRC; i >= 1; i--) begin
            if (src_valid[SRC_W'((int'(r_last) + i) % N_SRC)]) begin
                w_found = 1'b1;
                w_pick  = SRC_W'((int'(r_last) + i) % N_SRC);
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_state == c_CAPTURE) begin
            w_ready[r_grant] = 1'b1;
        end
    end

    assign w_char = src_char[{r_grant, 3'b000} +: 8];
    assign w_xfer = (r_state == c_CAPTURE) && src_valid[r_grant];

    // Buffer write port: '^' always lands in entry 0; other chars append
    // while the record is open and there is room.
    always_comb begin
        w_buf_we    = 1'b0;
        w_buf_waddr = '0;
        if (w_xfer) begin
            if (w_char == c_SOR) begin
                w_buf_we = 1'b1;
            end else if ((r_len != '0) && (r_len != c_FULL)) begin
                w_buf_we    = 1'b1;
                w_buf_waddr = r_len[c_AW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[w_buf_waddr] <= w_char;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_last       <= SRC_W'(N_SRC - 1);
            r_grant      <= '0;
            r_len        <= '0;
            r_idx        <= '0;
            r_tmo        <= '0;
            r_chk_char   <= IDLE_CHAR;
            r_res_src    <= '0;
            r_res_format <= '0;
            r_res_error  <= '0;
            r_drop_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_chk_char <= IDLE_CHAR;
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_last  <= w_pick;
                        r_len   <= '0;
                        r_tmo   <= '0;
                        r_state <= c_CAPTURE;
                    end
                end
                c_CAPTURE: begin
                    if (w_xfer) begin
                        r_tmo <= '0;
                        if (w_char == c_SOR) begin
                            r_len <= LEN_W'(1);
                        end else if (r_len == '0) begin
                            r_len <= '0;            // line noise before '^'
                        end else if (r_len == c_FULL) begin
                            // No room left, not even for the terminating '#'
                            r_len   <= '0;
                            r_state <= c_IDLE;
                            if (r_drop_cnt != 8'hFF) begin
                                r_drop_cnt <= r_drop_cnt + 8'd1;
                            end
                        end else begin
                            r_len <= r_len + LEN_W'(1);
                            if (w_char == c_EOR) begin
                                // Preload entry 0 so '^' is on the wire in
                                // the very first replay cycle.
                                r_chk_char <= r_buf[0];
                                r_idx      <= LEN_W'(1);
                                r_state    <= c_REPLAY;
                            end
                        end
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_len   <= '0;
                        r_state <= c_IDLE;
                        if (r_drop_cnt != 8'hFF) begin
                            r_drop_cnt <= r_drop_cnt + 8'd1;
                        end
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                c_REPLAY: begin
                    if (r_idx == r_len) begin
                        r_chk_char <= IDLE_CHAR;
                        r_state    <= c_WAIT_RES;
                    end else begin
                        r_chk_char <= r_buf[r_idx[c_AW-1:0]];
                        r_idx      <= r_idx + LEN_W'(1);
                    end
                end
                c_WAIT_RES: begin
                    r_res_format <= chk_format_type;
                    r_res_error  <= chk_error_code;
                    r_res_src    <= r_grant;
                    r_state      <= c_REPORT;
                end
                c_REPORT: begin
                    r_len   <= '0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_len      <= '0;
                    r_chk_char <= IDLE_CHAR;
                    r_state    <= c_IDLE;
                end
            endcase
        end
    end

    assign src_ready  = w_ready;
    assign chk_char   = r_chk_char;
    assign res_valid  = (r_state == c_REPORT);
    assign res_src    = r_res_src;
    assign res_format = r_res_format;
    assign res_error  = r_res_error;
    assign busy       = (r_state != c_IDLE);
    assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_trace_char_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_char_arbiter
// Purpose  : Directed self-checking bench for trace_char_arbiter. Source
//            strings are fed through the valid/ready handshake; the replayed
//            char stream, results, grants and drop events are collected and
//            compared against hand-derived expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_char_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   src_valid;
    logic [8*N-1:0] src_char;
    logic [N-1:0]   src_ready;
    logic [7:0]     chk_char;
    logic [1:0]     chk_format_type;
    logic [3:0]     chk_error_code;
    logic           res_valid;
    logic [1:0]     res_src;
    logic [1:0]     res_format;
    logic [3:0]     res_error;
    logic           busy;
    logic [7:0]     drop_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trace_char_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .src_valid       (src_valid),
        .src_char        (src_char),
        .src_ready       (src_ready),
        .chk_char        (chk_char),
        .chk_format_type (chk_format_type),
        .chk_error_code  (chk_error_code),
        .res_valid       (res_valid),
        .res_src         (res_src),
        .res_format      (res_format),
        .res_error       (res_error),
        .busy            (busy),
        .drop_cnt        (drop_cnt)
    );

    string s_data [N];
    int    s_pos  [N];
    int    cyc;
    byte   rep_q [$];
    int    rep_first;
    int    res_src_q [$];
    int    res_fmt_q [$];
    int    res_err_q [$];
    int    res_cyc_q [$];
    int    res_drop_q [$];
    int    grant_q [$];
    int    drop_pos0 [$];
    int    hash_cyc;
    int    last_xfer_cyc;
    int    drop_chg_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (s_pos[i] < s_data[i].len()) begin
                src_valid[i]       = 1'b1;
                src_char[8*i +: 8] = s_data[i][s_pos[i]];
            end else begin
                src_valid[i]       = 1'b0;
                src_char[8*i +: 8] = 8'h00;
            end
        end
    endtask

    task automatic load(input int i, input string s);
        s_data[i] = s;
        s_pos[i]  = 0;
    endtask

    task automatic clear_mon();
        rep_q.delete();
        res_src_q.delete();
        res_fmt_q.delete();
        res_err_q.delete();
        res_cyc_q.delete();
        res_drop_q.delete();
        grant_q.delete();
        drop_pos0.delete();
        rep_first     = -1;
        hash_cyc      = -1;
        last_xfer_cyc = -1;
        drop_chg_cyc  = -1;
    endtask

    // One clock: record handshakes before the edge, then sample outputs
    // and re-drive sources 1 time unit after it.
    task automatic tick();
        logic [N-1:0] acc;
        logic         pbusy;
        logic [7:0]   pdrop;
        acc   = src_valid & src_ready;
        pbusy = busy;
        pdrop = drop_cnt;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                last_xfer_cyc = cyc;
                if (s_data[i][s_pos[i]] == "#") hash_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) s_pos[i]++;
        end
        drive();
        if (chk_char != 8'h00) begin
            if (rep_q.size() == 0) rep_first = cyc;
            rep_q.push_back(chk_char);
        end
        if (res_valid) begin
            res_src_q.push_back(int'(res_src));
            res_fmt_q.push_back(int'(res_format));
            res_err_q.push_back(int'(res_error));
            res_cyc_q.push_back(cyc);
            res_drop_q.push_back(int'(drop_cnt));
        end
        if (busy && !pbusy) begin
            for (int i = 0; i < N; i++) begin
                if (src_ready[i]) grant_q.push_back(i);
            end
        end
        if (drop_cnt != pdrop) begin
            drop_chg_cyc = cyc;
            drop_pos0.push_back(s_pos[0]);
        end
    endtask

    function automatic bit drained();
        bit d = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (s_pos[i] < s_data[i].len()) d = 1'b0;
        end
        return d;
    endfunction

    task automatic run_idle(input string tag, input int bound);
        int n = 0;
        while (!(drained() && !busy) && n < bound) begin
            tick();
            n++;
        end
        check({tag, "_completes"}, 32'(n < bound), 32'd1);
    endtask

    task automatic check_rep(input string tag, input string exp);
        int bad = -1;
        check({tag, "_len"}, rep_q.size(), exp.len());
        for (int k = 0; k < exp.len() && k < rep_q.size(); k++) begin
            if (bad < 0 && rep_q[k] != exp[k]) bad = k;
        end
        check({tag, "_first_bad_idx"}, bad, -1);
    endtask

    initial begin
        string rec1;
        string ovf;
        int    n;
        rec1 = "^10@00003004: $1 <= 0000abcd#";
        cyc  = 0;
        reset = 1'b1;
        src_valid = '0;
        src_char  = '0;
        chk_format_type = 2'b00;
        chk_error_code  = 4'h0;
        for (int i = 0; i < N; i++) load(i, "");
        clear_mon();
        tick();
        tick();

        // Reset state
        check("rst_src_ready", src_ready, 0);
        check("rst_chk_char", chk_char, 8'h00);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_src", res_src, 0);
        check("rst_res_format", res_format, 0);
        check("rst_res_error", res_error, 0);
        check("rst_busy", busy, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        reset = 1'b0;

        // Single record from source 0
        clear_mon();
        chk_format_type = 2'b01;
        chk_error_code  = 4'h0;
        load(0, rec1);
        drive();
        run_idle("t1", 300);
        check_rep("t1_rep", rec1);
        check("t1_first_rep_lat", rep_first - hash_cyc, 1);
        check("t1_res_count", res_src_q.size(), 1);
        if (res_src_q.size() > 0) begin
            check("t1_res_lat", res_cyc_q[0] - hash_cyc, 31);
            check("t1_res_src", res_src_q[0], 0);
            check("t1_res_format", res_fmt_q[0], 1);
            check("t1_res_error", res_err_q[0], 0);
        end

        // Fairness: 1 and 3 straight after reset, then all four
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_mon();
        chk_format_type = 2'b10;
        chk_error_code  = 4'h5;
        load(1, "^a#");
        load(3, "^b#");
        drive();
        run_idle("t2a", 300);
        check("t2a_grants", grant_q.size(), 2);
        if (grant_q.size() >= 2) begin
            check("t2a_grant0", grant_q[0], 1);
            check("t2a_grant1", grant_q[1], 3);
        end
        clear_mon();
        for (int i = 0; i < N; i++) load(i, "^c#");
        drive();
        run_idle("t2b", 400);
        check("t2b_grants", grant_q.size(), 4);
        if (grant_q.size() >= 4) begin
            check("t2b_grant0", grant_q[0], 0);
            check("t2b_grant1", grant_q[1], 1);
            check("t2b_grant2", grant_q[2], 2);
            check("t2b_grant3", grant_q[3], 3);
        end
        check("t2b_res_count", res_src_q.size(), 4);
        if (res_src_q.size() >= 4) begin
            check("t2b_res_src3", res_src_q[3], 3);
            check("t2b_res_format", res_fmt_q[3], 2);
            check("t2b_res_error", res_err_q[3], 5);
        end

        // Line noise before '^', then '^' restart
        clear_mon();
        load(2, "xy^12@0#");
        drive();
        run_idle("t3a", 300);
        check_rep("t3a_rep", "^12@0#");
        clear_mon();
        load(2, "^1^2@00003000: *00000000 <= 00000001#");
        drive();
        run_idle("t3b", 300);
        check_rep("t3b_rep", "^2@00003000: *00000000 <= 00000001#");
        check("t3b_drop_cnt", drop_cnt, 0);

        // Overflow: '^' + 70 filler; leftover filler later times out
        clear_mon();
        ovf = "^";
        for (int k = 0; k < 70; k++) ovf = {ovf, "a"};
        load(0, ovf);
        load(1, "^b#");
        drive();
        run_idle("t4", 2000);
        check("t4_res_count", res_src_q.size(), 1);
        if (res_src_q.size() > 0) begin
            check("t4_res_src", res_src_q[0], 1);
            check("t4_drop_at_res", res_drop_q[0], 1);
        end
        check("t4_drops", drop_pos0.size(), 2);
        if (drop_pos0.size() > 0) check("t4_ovf_accepted", drop_pos0[0], 65);
        check("t4_grants", grant_q.size(), 3);
        if (grant_q.size() >= 2) begin
            check("t4_grant0", grant_q[0], 0);
            check("t4_grant1", grant_q[1], 1);
        end
        check_rep("t4_rep", "^b#");
        check("t4_drop_cnt", drop_cnt, 2);

        // Timeout after a partial record
        clear_mon();
        load(1, "^5@");
        drive();
        run_idle("t5", 1000);
        check("t5_drop_cnt", drop_cnt, 3);
        check("t5_drop_lat", drop_chg_cyc - last_xfer_cyc, 256);
        check("t5_no_replay", rep_q.size(), 0);
        check("t5_no_res", res_src_q.size(), 0);
        check("t5_grant", (grant_q.size() > 0) ? grant_q[0] : -1, 1);

        // Reset during the 10th replay cycle
        clear_mon();
        load(0, rec1);
        drive();
        n = 0;
        while (rep_q.size() < 10 && n < 200) begin
            tick();
            n++;
        end
        check("t6_reach_replay", 32'(n < 200), 1);
        reset = 1'b1;
        tick();
        check("t6_chk_char", chk_char, 8'h00);
        check("t6_busy", busy, 0);
        check("t6_res_valid", res_valid, 0);
        check("t6_drop_cnt", drop_cnt, 0);
        check("t6_src_ready", src_ready, 0);
        reset = 1'b0;
        clear_mon();
        load(3, "^d#");
        load(0, "^e#");
        drive();
        run_idle("t6", 300);
        check("t6_grant_first", (grant_q.size() > 0) ? grant_q[0] : -1, 0);
        check("t6_res_count", res_src_q.size(), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
